// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two prioritised write
// ports, optional write-to-read bypass, a per-register busy scoreboard and a
// post-reset clear sequencer that zeroes every register before use.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          rw0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          rw1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       bset,
  input  logic [ADDR_W-1:0]          bset_addr,
  output logic                       ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // True when the address names the hard-wired zero register.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  // A write is live only when enabled and not aimed at the zero register.
  logic w0_live_s, w1_live_s;
  assign w0_live_s = we0 & ~is_zero_addr(rw0);
  assign w1_live_s = we1 & ~is_zero_addr(rw1);

  // Next-state logic: clear sequencer, prioritised writes and busy scoreboard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    case (state_q)
      ST_CLEAR: begin
        // Ports are ignored; walk the file writing zeros, stop on the last entry.
        mem_d[cnt_q] = {DATA_W{1'b0}};
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        // Port 1 is applied last so it wins an address collision.
        if (w0_live_s) begin
          mem_d[rw0] = wd0;
        end else begin
          mem_d = mem_d;
        end
        if (w1_live_s) begin
          mem_d[rw1] = wd1;
        end else begin
          mem_d = mem_d;
        end
        // Completion clears busy; a new issue to the same register overrides it.
        if (we0) begin
          busy_d[rw0] = 1'b0;
        end else begin
          busy_d = busy_d;
        end
        if (we1) begin
          busy_d[rw1] = 1'b0;
        end else begin
          busy_d = busy_d;
        end
        if (bset && !is_zero_addr(bset_addr)) begin
          busy_d[bset_addr] = 1'b1;
        end else begin
          busy_d = busy_d;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {ADDR_W{1'b0}};
        ready_d = 1'b0;
        busy_d  = {DEPTH{1'b0}};
      end
    endcase
  end

  // Control and scoreboard flops; reset restarts the clear sequence from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {ADDR_W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= {DEPTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Register array; contents are left alone in the reset cycle itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  assign ready = ready_q;

  // Combinational read ports with optional same-cycle write forwarding.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              hit0_s, hit1_s;

    assign addr_s = ra[k*ADDR_W +: ADDR_W];
    assign hit0_s = (BYPASS != 0) && w0_live_s && (rw0 == addr_s);
    assign hit1_s = (BYPASS != 0) && w1_live_s && (rw1 == addr_s);

    // Select stored or forwarded data; outputs read as zero until the file is ready.
    always_comb begin
      data_s = mem_q[addr_s];
      if (!ready_q || is_zero_addr(addr_s)) begin
        data_s = {DATA_W{1'b0}};
      end else if (hit1_s) begin
        data_s = wd1;
      end else if (hit0_s) begin
        data_s = wd0;
      end else begin
        data_s = mem_q[addr_s];
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = data_s;
    assign rbusy[k]                  = ready_q & busy_q[addr_s];
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file: the successor to the single-write, two-read CPU register file. It adds:
- configurable width, depth and read-port count
- two write ports with fixed priority
- optional write-to-read bypass
- a per-register busy scoreboard for pipelined issue
- a sequential post-reset clear sequencer

It sits between decode (reads, busy set) and writeback (writes, busy clear) in the pipelined core.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and busy-set
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
ra  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, same packing as ra
rbusy  out  NUM_RD  busy bit of each read port's register
we0  in  1  write enable, port 0
rw0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
rw1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
bset  in  1  mark register bset_addr busy (destination issued)
bset_addr  in  ADDR_W  register to mark busy
ready  out  1  1 = clear sequence done, file usable

Behaviour:
- Reset (rst=1 at an edge):
  - ready<=0, all busy bits<=0, clear counter<=0, FSM<=CLEAR.
  - Register contents are cleared by the sequencer, not in that cycle.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from counter 0.
- FSM state CLEAR:
  - Each cycle writes 0 to reg[counter], then counter+1.
  - After writing reg[2**ADDR_W-1], next state RUN, ready<=1.
  - Exactly 2**ADDR_W cycles from rst deassertion to ready=1 (32 for defaults).
  - we0/we1/bset are ignored.
  - rdata is forced to 0 and rbusy to 0 while ready=0.
- FSM state RUN:
  - Writes occur at the rising edge when weN=1.
  - If rw0==rw1 with both enabled, wd1 is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads are combinational, with no read latency: rdata[k] = reg[ra[k]].
- BYPASS=1: if a write is enabled in the current cycle to ra[k] (and is not a dropped addr-0 write), rdata[k] returns that write's data; port 1 data wins on a double match. BYPASS=0 returns the old value until the edge.
- Scoreboard:
  - A write on either port clears busy[rw] at the edge.
  - bset sets busy[bset_addr] at the edge.
  - If set and clear hit the same address in the same cycle, set wins (a new producer supersedes).
  - busy[0] is never set when ZERO_REG=1.
  - rbusy[k] = busy[ra[k]], combinational.
  - rbusy is not bypassed: a clearing write in the current cycle still shows busy=1 until the edge.
- Widths: addresses are unsigned; no wrap logic is needed beyond the counter, which stops in RUN.
- No X on outputs after reset: all storage is defined by the end of CLEAR.

Test Plan:
1. Reset clear: preload reg5=0xDEADBEEF, pulse rst one cycle, read ra0=5 each cycle -> ready=0 and rdata=0 for 32 cycles, then ready=1 and rdata=0x00000000.
2. Dual write collision: we0=we1=1, rw0=rw1=7, wd0=0x11111111, wd1=0x22222222 -> next cycle ra0=7 reads 0x22222222.
3. Bypass: BYPASS=1, reg3=0x5; in the same cycle we0=1, rw0=3, wd0=0xA5A5A5A5, ra1=3 -> rdata port1=0xA5A5A5A5 that cycle. Repeat with BYPASS=0 -> rdata=0x5, then 0xA5A5A5A5 next cycle.
4. Zero register: we1=1, rw1=0, wd1=0xFFFFFFFF, bset=1, bset_addr=0 -> ra0=0 reads 0 and rbusy0=0 in the same and all later cycles.
5. Scoreboard: bset addr 9 -> rbusy=1 next cycle. Then we0 rw0=9 together with bset addr 9 in the same cycle -> still busy. Then we0 rw0=9 alone -> rbusy=0 after the edge.
6. Reset mid-clear: assert rst at clear count 10 -> ready rises exactly 32 cycles after the second rst deassertion; writes attempted during CLEAR are not retained.
